// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA CPU-side VRAM port.
package cga_pkg;

  localparam logic [19:0] CGA_FB_BASE  = 20'hB8000;
  localparam logic [3:0]  CGA_RAM_PAGE = 4'b0001;

  // Posted-write word: {offset[14:0], data[7:0]}
  localparam int unsigned CGA_WR_W = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_RD_HOLD
  } cga_state_e;

endpackage

// File: rtl/cga_post_fifo.sv
// Small synchronous FIFO holding posted CPU writes until a RAM slot frees up.
module cga_post_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted when a pop frees a slot in the same clk.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cga_vram_cpu_port.sv
// CPU-side VRAM port: decodes ISA cycles in the framebuffer window, posts
// writes into a FIFO and serves reads only in the sequencer's free RAM slot.
module cga_vram_cpu_port
  import cga_pkg::*;
#(
  parameter logic [19:0] FB_BASE    = CGA_FB_BASE,
  parameter logic [3:0]  RAM_PAGE   = CGA_RAM_PAGE,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] bus_a,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic        bus_aen,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        bus_rdy,
  input  logic        isa_slot,
  input  logic [7:0]  ram_d,
  output logic        cpu_ram_sel,
  output logic [18:0] cpu_ram_a,
  output logic [7:0]  cpu_ram_dout,
  output logic        cpu_ram_we_l
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                cs;
  logic [2:0]          memr_q;
  logic [2:0]          memw_q;
  logic                memr_sync;
  logic                memw_sync;
  logic                rd_edge;
  logic                wr_edge;
  cga_state_e          state;
  cga_state_e          state_n;
  logic                rd_pend;
  logic                rd_valid;
  logic [14:0]         rd_addr;
  logic                wr_hold;
  logic                wr_acc;
  logic [CGA_WR_W-1:0] hold_word;
  logic [CGA_WR_W-1:0] wr_word;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [CGA_WR_W-1:0] fifo_din;
  logic [CGA_WR_W-1:0] fifo_dout;
  logic                hold_push;
  logic                direct_push;
  logic                hold_set;

  assign cs        = (bus_a[19:15] == FB_BASE[19:15]) & ~bus_aen;
  assign memr_sync = memr_q[1];
  assign memw_sync = memw_q[1];
  assign rd_edge   = memr_q[2] & ~memr_q[1] & cs;
  assign wr_edge   = memw_q[2] & ~memw_q[1] & cs;
  assign wr_word   = {bus_a[14:0], bus_d};

  assign fifo_pop    = (state == ST_WR) & ~fifo_empty;
  assign hold_push   = wr_hold & fifo_pop;
  assign direct_push = wr_edge & ~wr_hold & (~fifo_full | fifo_pop);
  assign hold_set    = wr_edge & ~wr_hold & fifo_full & ~fifo_pop;
  assign fifo_push   = hold_push | direct_push;
  assign fifo_din    = wr_hold ? hold_word : wr_word;

  // wr_acc masks the full term once this strobe's write is in the FIFO, so a
  // write that fills the FIFO (or a held write retired by a pop that leaves it
  // full) releases IOCHRDY instead of stalling until a further slot.
  assign bus_rdy = ~((cs & ~bus_memr_l & ~rd_valid) |
                     (cs & ~bus_memw_l & (fifo_full | wr_hold) & ~wr_acc));
  assign bus_dir = cs & ~bus_memr_l & rd_valid;

  cga_post_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CGA_WR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Strobe synchronisers; bit 2 keeps the previous synced value for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memr_q <= '1;
      memw_q <= '1;
    end else begin
      memr_q <= {memr_q[1:0], bus_memr_l};
      memw_q <= {memw_q[1:0], bus_memw_l};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state and RAM-side outputs; writes always drain before a read issues.
  always_comb begin
    state_n      = state;
    cpu_ram_sel  = 1'b0;
    cpu_ram_we_l = 1'b1;
    cpu_ram_a    = '0;
    cpu_ram_dout = '0;
    case (state)
      ST_IDLE: begin
        if (isa_slot) begin
          if (fifo_count != '0) state_n = ST_WR;
          else if (rd_pend)     state_n = ST_RD_ADDR;
        end
      end
      ST_WR: begin
        cpu_ram_sel  = 1'b1;
        cpu_ram_we_l = 1'b0;
        cpu_ram_a    = {RAM_PAGE, fifo_dout[CGA_WR_W-1:8]};
        cpu_ram_dout = fifo_dout[7:0];
        state_n      = ST_IDLE;
      end
      ST_RD_ADDR: begin
        cpu_ram_sel = 1'b1;
        cpu_ram_a   = {RAM_PAGE, rd_addr};
        state_n     = ST_RD_CAP;
      end
      ST_RD_CAP:  state_n = ST_RD_HOLD;
      ST_RD_HOLD: if (memr_sync) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Read request tracking and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      bus_out  <= '0;
    end else begin
      if (state == ST_RD_ADDR) begin
        rd_pend  <= 1'b0;
        rd_valid <= 1'b1;
        bus_out  <= ram_d;
      end else if (rd_edge) begin
        rd_pend <= 1'b1;
        rd_addr <= bus_a[14:0];
      end
      if ((state == ST_RD_HOLD) && memr_sync) rd_valid <= 1'b0;
    end
  end

  // Held write when the FIFO is full, and per-strobe write acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_hold   <= 1'b0;
      wr_acc    <= 1'b0;
      hold_word <= '0;
    end else begin
      if (hold_push) begin
        wr_hold <= 1'b0;
      end else if (hold_set) begin
        wr_hold   <= 1'b1;
        hold_word <= wr_word;
      end
      if (direct_push | hold_push) wr_acc <= 1'b1;
      else if (memw_sync)          wr_acc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cga_vram_cpu_port.sv
// Directed bench for the CGA CPU-side VRAM port.
module tb_cga_vram_cpu_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] bus_a;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_d;
  logic [7:0]  bus_out;
  logic        bus_dir;
  logic        bus_rdy;
  logic        isa_slot;
  logic [7:0]  ram_d;
  logic        cpu_ram_sel;
  logic [18:0] cpu_ram_a;
  logic [7:0]  cpu_ram_dout;
  logic        cpu_ram_we_l;

  int checks = 0;
  int errors = 0;

  // Simple RAM: write on clk when selected, read data follows the address.
  logic [7:0] ram_mem [32768];
  assign ram_d = ram_mem[cpu_ram_a[14:0]];
  always @(posedge clk) begin
    if (cpu_ram_sel && !cpu_ram_we_l) ram_mem[cpu_ram_a[14:0]] <= cpu_ram_dout;
  end

  always #5 clk = ~clk;

  cga_vram_cpu_port #(
    .FB_BASE    (20'hB8000),
    .RAM_PAGE   (4'b0001),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_a        (bus_a),
    .bus_memr_l   (bus_memr_l),
    .bus_memw_l   (bus_memw_l),
    .bus_aen      (bus_aen),
    .bus_d        (bus_d),
    .bus_out      (bus_out),
    .bus_dir      (bus_dir),
    .bus_rdy      (bus_rdy),
    .isa_slot     (isa_slot),
    .ram_d        (ram_d),
    .cpu_ram_sel  (cpu_ram_sel),
    .cpu_ram_a    (cpu_ram_a),
    .cpu_ram_dout (cpu_ram_dout),
    .cpu_ram_we_l (cpu_ram_we_l)
  );

  // One ISA write cycle, long enough for the synchroniser to see both edges.
  task automatic cpu_write(input logic [19:0] a, input logic [7:0] d);
    bus_a = a; bus_d = d; bus_memw_l = 1'b0;
    repeat (4) @(negedge clk);
    bus_memw_l = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One-clk slot pulse; returns at the negedge after the sampling posedge.
  task automatic pulse_slot;
    isa_slot = 1'b1;
    @(negedge clk);
    isa_slot = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus_a = '0; bus_d = '0; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
    bus_aen = 1'b0; isa_slot = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL rst_bus_out got %h exp 00", bus_out); end
    checks++; if (bus_dir !== 1'b0) begin errors++; $display("FAIL rst_bus_dir got %b exp 0", bus_dir); end
    checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL rst_bus_rdy got %b exp 1", bus_rdy); end
    checks++; if (cpu_ram_sel !== 1'b0) begin errors++; $display("FAIL rst_sel got %b exp 0", cpu_ram_sel); end
    checks++; if (cpu_ram_we_l !== 1'b1) begin errors++; $display("FAIL rst_we_l got %b exp 1", cpu_ram_we_l); end
    checks++; if (cpu_ram_a !== 19'h0) begin errors++; $display("FAIL rst_a got %h exp 00000", cpu_ram_a); end
    checks++; if (cpu_ram_dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %h exp 00", cpu_ram_dout); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    cpu_write(20'hB8010, 8'h5A);
    checks++; if (dut.u_fifo.count !== 3'd1) begin errors++; $display("FAIL t1_count got %0d exp 1", dut.u_fifo.count); end
    pulse_slot();
    checks++; if (cpu_ram_sel !== 1'b1) begin errors++; $display("FAIL t1_sel got %b exp 1", cpu_ram_sel); end
    checks++; if (cpu_ram_we_l !== 1'b0) begin errors++; $display("FAIL t1_we_l got %b exp 0", cpu_ram_we_l); end
    checks++; if (cpu_ram_a !== 19'h08010) begin errors++; $display("FAIL t1_a got %h exp 08010", cpu_ram_a); end
    checks++; if (cpu_ram_dout !== 8'h5A) begin errors++; $display("FAIL t1_dout got %h exp 5a", cpu_ram_dout); end
    @(negedge clk);
    checks++; if (cpu_ram_sel !== 1'b0) begin errors++; $display("FAIL t1_sel_after got %b exp 0", cpu_ram_sel); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL t1_count_after got %0d exp 0", dut.u_fifo.count); end
  endtask

  task automatic test_full_hold;
    logic [7:0] exp_d [5];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44; exp_d[4] = 8'h55;
    for (int unsigned i = 0; i < 4; i++) cpu_write(20'hB8100 + 20'(i), exp_d[i]);
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL t2_count4 got %0d exp 4", dut.u_fifo.count); end
    bus_a = 20'hB8104; bus_d = 8'h55; bus_memw_l = 1'b0;
    #1;
    checks++; if (bus_rdy !== 1'b0) begin errors++; $display("FAIL t2_rdy_imm got %b exp 0", bus_rdy); end
    repeat (6) @(negedge clk);
    checks++; if (bus_rdy !== 1'b0) begin errors++; $display("FAIL t2_rdy_wait got %b exp 0", bus_rdy); end
    pulse_slot();
    checks++; if (cpu_ram_a !== 19'h08100) begin errors++; $display("FAIL t2_pop0_a got %h exp 08100", cpu_ram_a); end
    checks++; if (cpu_ram_dout !== 8'h11) begin errors++; $display("FAIL t2_pop0_dout got %h exp 11", cpu_ram_dout); end
    @(negedge clk);
    checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL t2_rdy_release got %b exp 1", bus_rdy); end
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL t2_count_after_hold got %0d exp 4", dut.u_fifo.count); end
    bus_memw_l = 1'b1;
    repeat (4) @(negedge clk);
    for (int unsigned i = 1; i < 5; i++) begin
      pulse_slot();
      checks++; if (cpu_ram_a !== (19'h08100 + 19'(i))) begin errors++; $display("FAIL t2_pop_a[%0d] got %h exp %h", i, cpu_ram_a, 19'h08100 + 19'(i)); end
      checks++; if (cpu_ram_dout !== exp_d[i]) begin errors++; $display("FAIL t2_pop_dout[%0d] got %h exp %h", i, cpu_ram_dout, exp_d[i]); end
      @(negedge clk);
    end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL t2_count_end got %0d exp 0", dut.u_fifo.count); end
  endtask

  task automatic test_push_pop_wrap;
    // Entering with both pointers at 2: entries land at 2, 3, then 0.
    cpu_write(20'hB8060, 8'hA1);
    cpu_write(20'hB8061, 8'hB2);
    checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL t6_count_pre got %0d exp 2", dut.u_fifo.count); end
    bus_a = 20'hB8062; bus_d = 8'hD4; bus_memw_l = 1'b0;
    @(negedge clk);
    isa_slot = 1'b1;
    @(negedge clk);
    isa_slot = 1'b0;
    checks++; if (cpu_ram_a !== 19'h08060) begin errors++; $display("FAIL t6_pop_a got %h exp 08060", cpu_ram_a); end
    checks++; if (cpu_ram_dout !== 8'hA1) begin errors++; $display("FAIL t6_pop_dout got %h exp a1", cpu_ram_dout); end
    @(negedge clk);
    checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL t6_count_same got %0d exp 2", dut.u_fifo.count); end
    checks++; if (dut.u_fifo.wr_ptr !== 2'd1) begin errors++; $display("FAIL t6_wr_ptr got %0d exp 1", dut.u_fifo.wr_ptr); end
    bus_memw_l = 1'b1;
    repeat (4) @(negedge clk);
    pulse_slot();
    checks++; if (cpu_ram_dout !== 8'hB2) begin errors++; $display("FAIL t6_pop1_dout got %h exp b2", cpu_ram_dout); end
    @(negedge clk);
    checks++; if (dut.u_fifo.rd_ptr !== 2'd0) begin errors++; $display("FAIL t6_rd_ptr_wrap got %0d exp 0", dut.u_fifo.rd_ptr); end
    pulse_slot();
    checks++; if (cpu_ram_a !== 19'h08062) begin errors++; $display("FAIL t6_pop2_a got %h exp 08062", cpu_ram_a); end
    checks++; if (cpu_ram_dout !== 8'hD4) begin errors++; $display("FAIL t6_pop2_dout got %h exp d4", cpu_ram_dout); end
    @(negedge clk);
  endtask

  task automatic test_read_after_write;
    cpu_write(20'hB8020, 8'hC3);
    bus_a = 20'hB8020; bus_memr_l = 1'b0;
    #1;
    checks++; if (bus_rdy !== 1'b0) begin errors++; $display("FAIL t3_rdy_imm got %b exp 0", bus_rdy); end
    repeat (4) @(negedge clk);
    pulse_slot();
    checks++; if (cpu_ram_we_l !== 1'b0) begin errors++; $display("FAIL t3_write_first got we_l %b exp 0", cpu_ram_we_l); end
    checks++; if (cpu_ram_dout !== 8'hC3) begin errors++; $display("FAIL t3_write_dout got %h exp c3", cpu_ram_dout); end
    @(negedge clk);
    checks++; if (bus_rdy !== 1'b0) begin errors++; $display("FAIL t3_rdy_waiting got %b exp 0", bus_rdy); end
    pulse_slot();
    checks++; if ({cpu_ram_sel, cpu_ram_we_l} !== 2'b11) begin errors++; $display("FAIL t3_rd_addr sel/we_l got %b exp 11", {cpu_ram_sel, cpu_ram_we_l}); end
    checks++; if (cpu_ram_a !== 19'h08020) begin errors++; $display("FAIL t3_rd_a got %h exp 08020", cpu_ram_a); end
    @(negedge clk);
    checks++; if (bus_out !== 8'hC3) begin errors++; $display("FAIL t3_bus_out got %h exp c3", bus_out); end
    checks++; if (bus_dir !== 1'b1) begin errors++; $display("FAIL t3_bus_dir got %b exp 1", bus_dir); end
    checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL t3_bus_rdy got %b exp 1", bus_rdy); end
    bus_memr_l = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus_out !== 8'hC3) begin errors++; $display("FAIL t3_bus_out_hold got %h exp c3", bus_out); end
    checks++; if (dut.rd_valid !== 1'b0) begin errors++; $display("FAIL t3_rd_valid_clear got %b exp 0", dut.rd_valid); end
    pulse_slot();
    checks++; if (cpu_ram_sel !== 1'b0) begin errors++; $display("FAIL t3_no_reissue got %b exp 0", cpu_ram_sel); end
    @(negedge clk);
  endtask

  task automatic test_no_decode;
    logic [19:0] addr [2];
    logic        aen  [2];
    addr[0] = 20'hB8030; aen[0] = 1'b1;
    addr[1] = 20'hB0000; aen[1] = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      bus_a = addr[i]; bus_aen = aen[i]; bus_d = 8'h99; bus_memw_l = 1'b0;
      #1;
      checks++; if (bus_rdy !== 1'b1) begin errors++; $display("FAIL t4_wr_rdy[%0d] got %b exp 1", i, bus_rdy); end
      repeat (4) @(negedge clk);
      checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL t4_count[%0d] got %0d exp 0", i, dut.u_fifo.count); end
      bus_memw_l = 1'b1;
      repeat (4) @(negedge clk);
      bus_memr_l = 1'b0;
      #1;
      checks++; if ({bus_rdy, bus_dir} !== 2'b10) begin errors++; $display("FAIL t4_rd_rdy_dir[%0d] got %b exp 10", i, {bus_rdy, bus_dir}); end
      repeat (4) @(negedge clk);
      checks++; if (dut.rd_pend !== 1'b0) begin errors++; $display("FAIL t4_rd_pend[%0d] got %b exp 0", i, dut.rd_pend); end
      bus_memr_l = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus_aen = 1'b0;
    pulse_slot();
    checks++; if (cpu_ram_sel !== 1'b0) begin errors++; $display("FAIL t4_slot_sel got %b exp 0", cpu_ram_sel); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    bus_a = 20'hB8040; bus_memr_l = 1'b0;
    repeat (4) @(negedge clk);
    pulse_slot();
    checks++; if ({cpu_ram_sel, cpu_ram_a} !== {1'b1, 19'h08040}) begin errors++; $display("FAIL t5_in_rd_addr got %b/%h exp 1/08040", cpu_ram_sel, cpu_ram_a); end
    reset = 1'b1; bus_memr_l = 1'b1;
    #1;
    checks++; if (cpu_ram_sel !== 1'b0) begin errors++; $display("FAIL t5_sel got %b exp 0", cpu_ram_sel); end
    checks++; if (cpu_ram_a !== 19'h0) begin errors++; $display("FAIL t5_a got %h exp 00000", cpu_ram_a); end
    checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL t5_bus_out got %h exp 00", bus_out); end
    checks++; if ({bus_dir, bus_rdy} !== 2'b01) begin errors++; $display("FAIL t5_dir_rdy got %b exp 01", {bus_dir, bus_rdy}); end
    checks++; if (dut.rd_pend !== 1'b0) begin errors++; $display("FAIL t5_rd_pend got %b exp 0", dut.rd_pend); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cpu_write(20'hB8050, 8'h01);
    cpu_write(20'hB8051, 8'h02);
    cpu_write(20'hB8052, 8'h03);
    pulse_slot();
    checks++; if (dut.u_fifo.count !== 3'd3) begin errors++; $display("FAIL t5_count_pre got %0d exp 3", dut.u_fifo.count); end
    reset = 1'b1;
    #1;
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL t5_count_reset got %0d exp 0", dut.u_fifo.count); end
    checks++; if ({cpu_ram_sel, cpu_ram_we_l, cpu_ram_dout} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL t5_wr_outputs got %b %b %h exp 0 1 00", cpu_ram_sel, cpu_ram_we_l, cpu_ram_dout); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_slot();
    checks++; if (cpu_ram_sel !== 1'b0) begin errors++; $display("FAIL t5_slot_after_reset got %b exp 0", cpu_ram_sel); end
    @(negedge clk);
    checks++; if (cpu_ram_sel !== 1'b0) begin errors++; $display("FAIL t5_idle_after_reset got %b exp 0", cpu_ram_sel); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_hold();
    test_push_pop_wrap();
    test_read_after_write();
    test_no_decode();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
